// File: rtl/eject_arbiter.sv
// eject_arbiter: round-robin N:1 arbiter feeding a single-entry output register.
// A consumer-ready output slot is refilled in the same cycle, giving one flit per cycle.
module eject_arbiter #(
   parameter int N  = 4,
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   input  logic            out_ready,
   output logic [15:0]     eject_cnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = 16;

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]    state;
   logic [0:0]    state_next;
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic [DW-1:0] data_next;
   logic [CW-1:0] cnt_next;

   logic [N-1:0]  grant;
   logic          grant_any;
   logic [PW-1:0] grant_ptr;
   logic [DW-1:0] grant_data;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   // First valid requester at or after ptr, wrapping modulo N.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_ptr = ptr;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = PW'(sum);
         if (!grant_any && req_valid[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_ptr  = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
         end
      end
   end

   // One-hot data select of the winning requester.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            grant_data = grant_data | req_data[i*DW +: DW];
         end
      end
   end

   // Next-state and grant logic; reset masks grants combinationally.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      data_next  = out_data;
      cnt_next   = eject_cnt;
      req_ready  = '0;
      case (state)
         EMPTY: begin
            if (grant_any && !reset) begin
               req_ready  = grant;
               state_next = FULL;
               ptr_next   = grant_ptr;
               data_next  = grant_data;
            end
         end
         FULL: begin
            if (out_ready) begin
               cnt_next = eject_cnt + CW'(1);
               if (grant_any && !reset) begin
                  req_ready  = grant;
                  ptr_next   = grant_ptr;
                  data_next  = grant_data;
               end else begin
                  state_next = EMPTY;
               end
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         ptr       <= '0;
         out_data  <= '0;
         eject_cnt <= '0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         out_data  <= data_next;
         eject_cnt <= cnt_next;
      end
   end

   assign out_valid = (state == FULL);

endmodule

// File: tb/tb_eject_arbiter.sv
// tb_eject_arbiter: directed and randomized checks of eject_arbiter against a
// round-robin reference model and an in-order flit scoreboard.
module tb_eject_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_ready;
   logic [15:0]     eject_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: output slot occupancy, contents, rotation pointer, counter.
   bit            m_full;
   logic [DW-1:0] m_data;
   int            m_ptr;
   logic [15:0]   m_cnt;

   logic [DW-1:0] sb_q[$];

   eject_arbiter #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .eject_cnt (eject_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void reset_model();
      m_full = 1'b0;
      m_data = '0;
      m_ptr  = 0;
      m_cnt  = '0;
   endfunction

   function automatic logic [DW-1:0] req_slice(int i);
      logic [N*DW-1:0] t;
      t = req_data >> (i * DW);
      return t[DW-1:0];
   endfunction

   function automatic int exp_grant();
      logic [N-1:0] t;
      if (reset) return -1;
      if (m_full && !out_ready) return -1;
      for (int k = 0; k < N; k++) begin
         t = req_valid >> ((m_ptr + k) % N);
         if (t[0]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(int i);
      if (i < 0) return '0;
      return N'(1) << i;
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic o);
      @(negedge clk);
      req_valid = v;
      out_ready = o;
      for (int i = 0; i < N; i++) begin
         req_data = {req_data[(N-1)*DW-1:0], DW'({$urandom, $urandom})};
      end
      #1;
   endtask

   task automatic advance();
      int            g;
      logic [DW-1:0] gd;
      bit            oxfer;
      g     = exp_grant();
      gd    = (g >= 0) ? req_slice(g) : '0;
      oxfer = m_full && out_ready;
      @(posedge clk);
      if (reset) begin
         reset_model();
      end else begin
         if (oxfer) m_cnt = m_cnt + 16'd1;
         if (g >= 0) begin
            m_full = 1'b1;
            m_data = gd;
            m_ptr  = (g + 1) % N;
         end else if (oxfer) begin
            m_full = 1'b0;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      reset_model();
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '1;
      out_ready = 1'b1;
      req_data  = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
      n_checks++; if (eject_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_eject_cnt got %h want 0", eject_cnt); end
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
      req_valid = '0;
      reset     = 1'b0;
      reset_model();
   endtask

   task automatic test_round_robin();
      logic [DW-1:0] prev_d;
      prev_d = '0;
      apply_reset();
      for (int c = 0; c < 3 * N; c++) begin
         drive('1, 1'b1);
         n_checks++;
         if (req_ready !== onehot(c % N)) begin
            n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, onehot(c % N));
         end
         n_checks++;
         if (out_valid !== (c > 0)) begin
            n_fail++; $display("FAIL rr_out_valid c=%0d got %b want %b", c, out_valid, (c > 0));
         end
         if (c > 0) begin
            n_checks++;
            if (out_data !== prev_d) begin
               n_fail++; $display("FAIL rr_out_data c=%0d got %h want %h", c, out_data, prev_d);
            end
            n_checks++;
            if (eject_cnt !== 16'(c - 1)) begin
               n_fail++; $display("FAIL rr_eject_cnt c=%0d got %0d want %0d", c, eject_cnt, c - 1);
            end
         end
         prev_d = req_slice(c % N);
         advance();
      end
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      apply_reset();
      drive(4'b0100, 1'b1);
      n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", req_ready); end
      d = req_slice(2);
      advance();
      drive(4'b1001, 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
      n_checks++; if (out_data !== d) begin n_fail++; $display("FAIL single_out_data got %h want %h", out_data, d); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_blocked got %b want 0000", req_ready); end
      advance();
      drive(4'b1001, 1'b1);
      n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3 got %b want 1000", req_ready); end
      advance();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d;
      apply_reset();
      drive(4'b0001, 1'b1);
      d = req_slice(0);
      advance();
      for (int k = 0; k < 5; k++) begin
         drive('1, 1'b0);
         n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_req_ready k=%0d got %b want 0000", k, req_ready); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid k=%0d got %b want 1", k, out_valid); end
         n_checks++; if (out_data !== d) begin n_fail++; $display("FAIL bp_out_data k=%0d got %h want %h", k, out_data, d); end
         advance();
      end
      drive('1, 1'b1);
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_resume got %b want 0010", req_ready); end
      advance();
   endtask

   task automatic test_wrap();
      logic [15:0] want [3];
      want[0] = 16'hFFFF;
      want[1] = 16'h0000;
      want[2] = 16'h0001;
      apply_reset();
      for (int c = 0; c < 70000 && m_cnt != 16'hFFFE; c++) begin
         drive('1, 1'b1);
         advance();
      end
      drive('1, 1'b1);
      n_checks++; if (eject_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload got %h want fffe", eject_cnt); end
      for (int k = 0; k < 3; k++) begin
         advance();
         drive('1, 1'b1);
         n_checks++;
         if (eject_cnt !== want[k]) begin
            n_fail++; $display("FAIL wrap_cnt k=%0d got %h want %h", k, eject_cnt, want[k]);
         end
      end
      advance();
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] d;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         drive('1, 1'b1);
         advance();
      end
      @(negedge clk);
      req_valid = '0;
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_out_valid got %b want 0", out_valid); end
      n_checks++; if (eject_cnt !== 16'h0) begin n_fail++; $display("FAIL async_eject_cnt got %h want 0", eject_cnt); end
      @(negedge clk);
      reset = 1'b0;
      reset_model();
      drive(4'b1000, 1'b1);
      n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL async_grant3 got %b want 1000", req_ready); end
      n_checks++; if (eject_cnt !== 16'h0) begin n_fail++; $display("FAIL async_no_count got %h want 0", eject_cnt); end
      d = req_slice(3);
      advance();
      drive('1, 1'b1);
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL async_ptr0 got %b want 0001", req_ready); end
      n_checks++; if (out_data !== d) begin n_fail++; $display("FAIL async_out_data got %h want %h", out_data, d); end
      advance();
   endtask

   task automatic test_random();
      logic [N-1:0]  exp;
      logic [N-1:0]  t;
      logic [DW-1:0] want;
      int            errs;
      errs = 0;
      apply_reset();
      sb_q.delete();
      for (int c = 0; c < 10000; c++) begin
         drive(N'($urandom), ($urandom_range(0, 3) != 0));
         exp = onehot(exp_grant());
         n_checks++;
         if (req_ready !== exp) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL rand_grant c=%0d got %b want %b", c, req_ready, exp);
         end
         n_checks++;
         if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL rand_onehot c=%0d got %b valid %b", c, req_ready, req_valid);
         end
         n_checks++;
         if (out_valid !== m_full || eject_cnt !== m_cnt) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL rand_state c=%0d got v=%b cnt=%0d want v=%b cnt=%0d", c, out_valid, eject_cnt, m_full, m_cnt);
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               if (errs++ < 10) $display("FAIL rand_dup c=%0d got %h want no transfer", c, out_data);
            end else begin
               want = sb_q.pop_front();
               if (out_data !== want) begin
                  n_fail++;
                  if (errs++ < 10) $display("FAIL rand_data c=%0d got %h want %h", c, out_data, want);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            t = req_ready >> i;
            if (t[0]) sb_q.push_back(req_slice(i));
         end
         advance();
      end
      drive('0, 1'b0);
      n_checks++;
      if (sb_q.size() != (out_valid ? 1 : 0)) begin
         n_fail++; $display("FAIL rand_lost got %0d pending want %0d", sb_q.size(), (out_valid ? 1 : 0));
      end
   endtask

   initial begin
      reset_model();
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_async_reset();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
